// File: rtl/dbg_pkg.sv
// Shared constants for the Wishbone debug master: command/response bytes
// and the controller state encoding.
package dbg_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_READ) || (b == CMD_WRITE);
    endfunction

endpackage

// File: rtl/wb_dbg_master_if.sv
// Wishbone initiator/target signal bundle used to hook the debug master
// onto an interconnect port.
interface wb_dbg_master_if;

    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err, rty
    );

endinterface

// File: rtl/wb_dbg_master.sv
// Byte-stream debug bridge: 'R'/'W' + 4 address bytes (+ 4 data bytes)
// become one Wishbone cycle; the result is reported back as response bytes.
module wb_dbg_master
    import dbg_pkg::*;
#(
    parameter int unsigned ack_timeout = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_stb,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned TMR_W = $clog2(ack_timeout + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ack_timeout - 1);

    state_t             state_q, state_d;
    logic               op_we_q, op_we_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [31:0]        resp_q, resp_d;
    logic [1:0]         resp_left_q, resp_left_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_stb_q, tx_stb_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic               overrun_q, overrun_d;
    logic               launch;
    logic               term;
    logic               term_ok;

    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        byte_cnt_d  = byte_cnt_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        timer_d     = timer_q;
        tx_data_d   = tx_data_q;
        tx_stb_d    = 1'b0;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        overrun_d   = overrun_q;
        launch      = 1'b0;
        term        = 1'b0;
        term_ok     = 1'b0;

        if (rx_stb && (state_q == ST_BUS || state_q == ST_RESP))
            overrun_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_stb && is_cmd(rx_data)) begin
                    op_we_d    = (rx_data == CMD_WRITE);
                    byte_cnt_d = '0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_stb) begin
                    adr_d      = {adr_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (op_we_q)
                            state_d = ST_WDATA;
                        else
                            launch = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (rx_stb) begin
                    wdat_d     = {wdat_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3)
                        launch = 1'b1;
                end
            end
            ST_BUS: begin
                // err/rty take priority over a simultaneous ack
                if (wb_err_i || wb_rty_i) begin
                    term = 1'b1;
                end else if (wb_ack_i) begin
                    term    = 1'b1;
                    term_ok = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    term = 1'b1;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end

                if (term) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_RESP;
                    if (term_ok && !op_we_q) begin
                        resp_d      = wb_dat_i;
                        resp_left_d = 2'd3;
                    end else begin
                        resp_d      = {(term_ok ? RSP_ACK : RSP_NAK), 24'h000000};
                        resp_left_d = '0;
                    end
                end
            end
            ST_RESP: begin
                // the stb-low check keeps strobes one cycle apart even if
                // the transmitter raises busy late
                if (!tx_busy && !tx_stb_q) begin
                    tx_stb_d    = 1'b1;
                    tx_data_d   = resp_q[31:24];
                    resp_d      = {resp_q[23:0], 8'h00};
                    resp_left_d = resp_left_q - 2'd1;
                    if (resp_left_q == '0)
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = op_we_q;
            sel_d   = '1;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_we_q     <= 1'b0;
            byte_cnt_q  <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
            timer_q     <= '0;
            tx_data_q   <= '0;
            tx_stb_q    <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_we_q     <= op_we_d;
            byte_cnt_q  <= byte_cnt_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            tx_stb_q    <= tx_stb_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            overrun_q   <= overrun_d;
        end
    end

    // address/data shift registers drive the bus directly; they only move
    // while cyc is low, so the request stays stable during the cycle
    assign wb_adr_o = adr_q;
    assign wb_dat_o = wdat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign tx_data  = tx_data_q;
    assign tx_stb   = tx_stb_q;
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Self-checking bench for wb_dbg_master: scripted scenarios plus randomized
// frames checked against a behavioural model of the expected bus cycle/response.
module tb_wb_dbg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_stb;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        overrun;
    logic [31:0] slv_rdata = 32'h0;

    wb_dbg_master_if bus ();
    assign bus.dat_r = slv_rdata;

    wb_dbg_master #(.ack_timeout(16)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_stb(rx_stb),
        .tx_data(tx_data), .tx_stb(tx_stb), .tx_busy(tx_busy),
        .wb_adr_o(bus.adr), .wb_dat_o(bus.dat_w), .wb_sel_o(bus.sel),
        .wb_we_o(bus.we), .wb_cyc_o(bus.cyc), .wb_stb_o(bus.stb),
        .wb_dat_i(bus.dat_r), .wb_ack_i(bus.ack), .wb_err_i(bus.err),
        .wb_rty_i(bus.rty),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // slave config: 0 ack, 1 err, 2 rty, 3 silent, 4 err+ack
    int          slv_mode = 0;
    int          slv_delay = 0;
    int          slv_cnt = 0;
    int          tx_busy_len = 0;
    int          busy_left = 0;
    bit          prev_stb = 1'b0;
    bit          in_txn = 1'b0;

    int          txn_cnt = 0;
    int          cap_len = 0;
    int          stab_viol = 0;
    int          tx_viol = 0;
    logic [31:0] cap_adr = '0;
    logic [31:0] cap_dat = '0;
    logic [3:0]  cap_sel = '0;
    logic        cap_we = 1'b0;
    logic [7:0]  txq[$];

    // Wishbone target: terminates slv_delay cycles after stb rises
    always @(negedge clk) begin
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.rty = 1'b0;
        if (bus.cyc && bus.stb) begin
            if (slv_cnt == slv_delay) begin
                case (slv_mode)
                    0: bus.ack = 1'b1;
                    1: bus.err = 1'b1;
                    2: bus.rty = 1'b1;
                    4: begin bus.ack = 1'b1; bus.err = 1'b1; end
                    default: ;
                endcase
            end
            slv_cnt++;
        end else begin
            slv_cnt = 0;
        end
    end

    // bus monitor: records each cycle and flags request changes mid-cycle
    always @(negedge clk) begin
        if (bus.cyc) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                txn_cnt++;
                cap_adr = bus.adr;
                cap_dat = bus.dat_w;
                cap_sel = bus.sel;
                cap_we  = bus.we;
                cap_len = 0;
            end else if (bus.adr !== cap_adr || bus.dat_w !== cap_dat ||
                         bus.sel !== cap_sel || bus.we !== cap_we) begin
                stab_viol++;
            end
            if (bus.stb !== 1'b1) stab_viol++;
            cap_len++;
        end else begin
            in_txn = 1'b0;
        end
    end

    // transmitter model: logs bytes, stays busy tx_busy_len cycles per byte
    always @(negedge clk) begin
        if (rst) begin
            busy_left = 0;
            tx_busy   = 1'b0;
            prev_stb  = 1'b0;
        end else begin
            if (tx_stb) begin
                if (tx_busy || prev_stb) tx_viol++;
                txq.push_back(tx_data);
                busy_left = tx_busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            tx_busy  = (busy_left > 0);
            prev_stb = tx_stb;
        end
    end

    function automatic logic [31:0] resp_word(input int base);
        logic [31:0] w = '0;
        for (int k = base; k < txq.size(); k++) w = {w[23:0], txq[k]};
        return w;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
    endtask

    task automatic send_cmd(input bit we, input logic [31:0] adr,
                            input logic [31:0] dat, input int unsigned maxgap);
        send_byte(we ? 8'h57 : 8'h52, $urandom_range(maxgap, 0));
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8], $urandom_range(maxgap, 0));
        if (we)
            for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8], $urandom_range(maxgap, 0));
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_stb, bus.cyc, bus.stb, bus.we, busy, overrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {tx_stb, bus.cyc, bus.stb, bus.we, busy, overrun});
        end
        checks++;
        if ({tx_data, bus.sel} !== 12'h0) begin
            errors++;
            $display("FAIL reset_tx_sel got %h exp 000", {tx_data, bus.sel});
        end
        checks++;
        if ({bus.adr, bus.dat_w} !== 64'h0) begin
            errors++;
            $display("FAIL reset_adr_dat got %h exp 0", {bus.adr, bus.dat_w});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int t_txn = txn_cnt;
        int t_tx  = txq.size();
        int t_st  = stab_viol;
        bit ok;
        slv_mode = 0; slv_delay = 2; tx_busy_len = 2;
        send_cmd(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        wait_idle(ok);
        checks++;
        if (!ok || txn_cnt - t_txn != 1) begin
            errors++;
            $display("FAIL write_txn got ok=%0d n=%0d exp ok=1 n=1", ok, txn_cnt - t_txn);
        end
        checks++;
        if ({cap_adr, cap_we, cap_sel} !== {32'h0000_0100, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL write_req got adr=%h we=%b sel=%h exp 00000100/1/f", cap_adr, cap_we, cap_sel);
        end
        checks++;
        if (cap_dat !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_dat got %h exp deadbeef", cap_dat);
        end
        checks++;
        if (cap_len != 3 || stab_viol != t_st) begin
            errors++;
            $display("FAIL write_cyc got len=%0d unstable=%0d exp len=3 unstable=0", cap_len, stab_viol - t_st);
        end
        checks++;
        if (txq.size() - t_tx != 1 || resp_word(t_tx) !== 32'h06) begin
            errors++;
            $display("FAIL write_resp got n=%0d val=%h exp n=1 val=06", txq.size() - t_tx, resp_word(t_tx));
        end
    endtask

    task automatic test_read();
        int t_txn = txn_cnt;
        int t_tx  = txq.size();
        int t_v   = tx_viol;
        bit ok;
        slv_mode = 0; slv_delay = 0; tx_busy_len = 3; slv_rdata = 32'h1234_5678;
        send_cmd(1'b0, 32'hF000_0004, 32'h0, 1);
        wait_idle(ok);
        checks++;
        if (!ok || txn_cnt - t_txn != 1 || cap_we !== 1'b0 || cap_adr !== 32'hF000_0004) begin
            errors++;
            $display("FAIL read_req got ok=%0d n=%0d we=%b adr=%h exp 1/1/0/f0000004", ok, txn_cnt - t_txn, cap_we, cap_adr);
        end
        checks++;
        if (cap_len != 1) begin
            errors++;
            $display("FAIL read_latency got %0d exp 1", cap_len);
        end
        checks++;
        if (txq.size() - t_tx != 4 || resp_word(t_tx) !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_resp got n=%0d val=%h exp n=4 val=12345678", txq.size() - t_tx, resp_word(t_tx));
        end
        checks++;
        if (tx_viol != t_v) begin
            errors++;
            $display("FAIL read_tx_handshake got %0d violations exp 0", tx_viol - t_v);
        end
    endtask

    task automatic test_timeout();
        int t_tx = txq.size();
        bit ok;
        slv_mode = 3; slv_delay = 0; tx_busy_len = 1;
        send_cmd(1'b0, 32'h0000_0040, 32'h0, 0);
        wait_idle(ok);
        checks++;
        if (!ok || cap_len != 16) begin
            errors++;
            $display("FAIL timeout_len got ok=%0d len=%0d exp ok=1 len=16", ok, cap_len);
        end
        checks++;
        if (txq.size() - t_tx != 1 || resp_word(t_tx) !== 32'h15) begin
            errors++;
            $display("FAIL timeout_resp got n=%0d val=%h exp n=1 val=15", txq.size() - t_tx, resp_word(t_tx));
        end
    endtask

    task automatic test_err_ack();
        int t_tx = txq.size();
        bit ok;
        slv_mode = 4; slv_delay = 1; tx_busy_len = 0;
        send_cmd(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 0);
        wait_idle(ok);
        checks++;
        if (!ok || cap_len != 2) begin
            errors++;
            $display("FAIL err_ack_len got ok=%0d len=%0d exp ok=1 len=2", ok, cap_len);
        end
        checks++;
        if (txq.size() - t_tx != 1 || resp_word(t_tx) !== 32'h15) begin
            errors++;
            $display("FAIL err_ack_resp got n=%0d val=%h exp n=1 val=15", txq.size() - t_tx, resp_word(t_tx));
        end
    endtask

    task automatic test_bad_cmd();
        int t_txn = txn_cnt;
        int t_tx  = txq.size();
        bit ok;
        send_byte(8'h41, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL bad_cmd_ignored got busy=%b overrun=%b exp 0/0", busy, overrun);
        end
        slv_mode = 0; slv_delay = 1; tx_busy_len = 1; slv_rdata = 32'hA5C3_0F96;
        send_cmd(1'b0, 32'h0000_0008, 32'h0, 0);
        wait_idle(ok);
        checks++;
        if (!ok || txn_cnt - t_txn != 1 || cap_adr !== 32'h0000_0008 ||
            resp_word(t_tx) !== 32'hA5C3_0F96 || txq.size() - t_tx != 4) begin
            errors++;
            $display("FAIL bad_cmd_then_read got ok=%0d n=%0d adr=%h resp=%h exp 1/1/00000008/a5c30f96",
                     ok, txn_cnt - t_txn, cap_adr, resp_word(t_tx));
        end
    endtask

    task automatic test_partial_frame();
        int t_txn = txn_cnt;
        int t_tx  = txq.size();
        bit ok;
        slv_mode = 0; slv_delay = 0; tx_busy_len = 0;
        send_byte(8'h57, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || txn_cnt != t_txn) begin
            errors++;
            $display("FAIL partial_wait got busy=%b n=%0d exp busy=1 n=0", busy, txn_cnt - t_txn);
        end
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), 0);
        wait_idle(ok);
        checks++;
        if (!ok || cap_adr !== 32'h1122_3344 || cap_dat !== 32'h9091_9293 || resp_word(t_tx) !== 32'h06) begin
            errors++;
            $display("FAIL partial_complete got ok=%0d adr=%h dat=%h resp=%h exp 1/11223344/90919293/06",
                     ok, cap_adr, cap_dat, resp_word(t_tx));
        end
    endtask

    task automatic test_overrun();
        int t_txn = txn_cnt;
        int t_tx  = txq.size();
        bit ok;
        slv_mode = 0; slv_delay = 6; tx_busy_len = 1; slv_rdata = 32'h0BAD_F00D;
        send_cmd(1'b0, 32'h0000_0010, 32'h0, 0);
        send_byte(8'h52, 1);
        wait_idle(ok);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag got %b exp 1", overrun);
        end
        checks++;
        if (!ok || txn_cnt - t_txn != 1 || txq.size() - t_tx != 4 || resp_word(t_tx) !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL overrun_resp got ok=%0d n=%0d bytes=%0d val=%h exp 1/1/4/0badf00d",
                     ok, txn_cnt - t_txn, txq.size() - t_tx, resp_word(t_tx));
        end
        repeat (5) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b exp 1", overrun);
        end
    endtask

    task automatic test_rst_mid_bus();
        int t_tx;
        slv_mode = 3; tx_busy_len = 0;
        send_cmd(1'b0, 32'h0000_0020, 32'h0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cyc !== 1'b1) begin
            errors++;
            $display("FAIL rst_bus_active got cyc=%b exp 1", bus.cyc);
        end
        t_tx = txq.size();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.cyc, bus.stb, busy, overrun, tx_stb} !== 5'b0) begin
            errors++;
            $display("FAIL rst_bus_drop got %b exp 00000", {bus.cyc, bus.stb, busy, overrun, tx_stb});
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (txq.size() != t_tx || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_resp got bytes=%0d busy=%b exp 0/0", txq.size() - t_tx, busy);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int t_txn = txn_cnt;
            int t_tx  = txq.size();
            int t_st  = stab_viol;
            int t_v   = tx_viol;
            bit we = 1'($urandom_range(1, 0));
            logic [31:0] adr = $urandom;
            logic [31:0] dat = $urandom;
            logic [7:0] junk;
            bit ok, done, good;
            int exp_len, exp_n;
            logic [31:0] exp_resp;
            slv_mode    = $urandom_range(4, 0);
            slv_delay   = $urandom_range(20, 0);
            slv_rdata   = $urandom;
            tx_busy_len = $urandom_range(3, 0);
            if ($urandom_range(3, 0) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'h52 || junk == 8'h57) junk = 8'h00;
                send_byte(junk, 1);
            end
            send_cmd(we, adr, dat, 2);
            wait_idle(ok);

            // model: target answers within 16 cycles or the master gives up
            done     = (slv_mode != 3) && (slv_delay < 16);
            good     = done && (slv_mode == 0);
            exp_len  = done ? slv_delay + 1 : 16;
            exp_n    = (good && !we) ? 4 : 1;
            exp_resp = !good ? 32'h15 : (we ? 32'h06 : slv_rdata);

            checks++;
            if (!ok || txn_cnt - t_txn != 1) begin
                errors++;
                $display("FAIL rand%0d_txn got ok=%0d n=%0d exp 1/1", it, ok, txn_cnt - t_txn);
            end
            checks++;
            if ({cap_adr, cap_we, cap_sel} !== {adr, we, 4'hF} || (we && cap_dat !== dat)) begin
                errors++;
                $display("FAIL rand%0d_req got adr=%h we=%b sel=%h dat=%h exp %h/%b/f/%h",
                         it, cap_adr, cap_we, cap_sel, cap_dat, adr, we, dat);
            end
            checks++;
            if (cap_len != exp_len || stab_viol != t_st) begin
                errors++;
                $display("FAIL rand%0d_cyc got len=%0d unstable=%0d exp len=%0d unstable=0",
                         it, cap_len, stab_viol - t_st, exp_len);
            end
            checks++;
            if (txq.size() - t_tx != exp_n || resp_word(t_tx) !== exp_resp || tx_viol != t_v) begin
                errors++;
                $display("FAIL rand%0d_resp got n=%0d val=%h viol=%0d exp n=%0d val=%h viol=0",
                         it, txq.size() - t_tx, resp_word(t_tx), tx_viol - t_v, exp_n, exp_resp);
            end
            checks++;
            if (overrun !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_overrun got %b exp 0", it, overrun);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_err_ack();
        test_bad_cmd();
        test_partial_frame();
        test_overrun();
        test_rst_mid_bus();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
